// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 definitions for the calculator datapath.
// Holds the FSM state encoding used by mul_seq, the IEEE-754 constants and
// field widths. No ports.
// Optional feature macro used by consumers: MUL_ROUND_EN (round-to-nearest-even).
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam int                 FP_BIAS    = 127;
  localparam logic [31:0]        FP_QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]   FP_EXP_MAX = 8'hFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_NORM = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: operand / result bundle of the sequential multiplier.
//   start      request, sampled by the multiplier only in IDLE
//   A, B       binary32 operands, captured on the accept edge
//   result     binary32 product, held until the next accepted start
//   overflow   exponent overflow flag
//   underflow  exponent underflow flag
//   enable     one-cycle done strobe
//   busy       multiplier not idle
// master: requester side; slave: multiplier side.
interface mul_seq_if;

  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        enable;
  logic        busy;

  modport master (
    output start, A, B,
    input  result, overflow, underflow, enable, busy
  );

  modport slave (
    input  start, A, B,
    output result, overflow, underflow, enable, busy
  );

endinterface

// File: rtl/export_result_mul.sv
// export_result_mul: combinational special-operand override for the
// multiplier output stage.
//   a_i, b_i        latched binary32 operands
//   temp_result_i   normalised / flag-forced product
//   result_o        final product
//   special_o       high when an operand special case replaced the product;
//                   the caller uses it to clear overflow/underflow
module export_result_mul
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] temp_result_i,
  output logic [31:0] result_o,
  output logic        special_o
);

  logic sign;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    sign   = a_i[31] ^ b_i[31];
    a_nan  = (a_i[30:23] == FP_EXP_MAX) && (a_i[22:0] != '0);
    b_nan  = (b_i[30:23] == FP_EXP_MAX) && (b_i[22:0] != '0);
    a_inf  = (a_i[30:23] == FP_EXP_MAX) && (a_i[22:0] == '0);
    b_inf  = (b_i[30:23] == FP_EXP_MAX) && (b_i[22:0] == '0);
    // exponent 0 covers true zero and denormals, which are flushed
    a_zero = (a_i[30:23] == '0);
    b_zero = (b_i[30:23] == '0);

    result_o  = temp_result_i;
    special_o = 1'b1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result_o = FP_QNAN;
    end else if (a_inf || b_inf) begin
      result_o = {sign, FP_EXP_MAX, {FRAC_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      result_o = {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    end else begin
      special_o = 1'b0;
    end
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential binary32 multiplier (radix-2 shift-add, 24 cycles,
// then one normalise/pack cycle). Fixed 26-clock latency from accept to
// the enable strobe.
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   bus        mul_seq_if slave: start, A, B in; result, overflow,
//              underflow, enable, busy out
// Build option: define MUL_ROUND_EN for round-to-nearest-even; otherwise
// the mantissa is truncated.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// MUL   | 24 shift-add iterations
// NORM  | normalise, exponent, special cases, register outputs
// DONE  | enable high for one cycle
module mul_seq
  import fp_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  mul_seq_if.slave    bus
);

  localparam logic [9:0] BIAS10 = 10'(FP_BIAS);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  // Low half starts as the multiplier and is consumed from bit 0 while the
  // product bits shift in from above; the upper half is the accumulator.
  logic [47:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic [24:0]        sum;
  logic [22:0]        frac_t, frac_n;
  logic [9:0]         e_raw;
  logic signed [9:0]  exp_n;
  logic               sign;
  logic [31:0]        temp_result, final_result;
  logic               ovf_n, unf_n, special;

  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    frac_t = p_q[47] ? p_q[46:24] : p_q[45:23];
    e_raw  = ({2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} + {9'd0, p_q[47]}) - BIAS10;
  end

`ifdef MUL_ROUND_EN
  logic        g_bit, r_bit, s_bit, rnd_up;
  logic [23:0] frac_rnd;

  always_comb begin
    g_bit    = p_q[47] ? p_q[23] : p_q[22];
    r_bit    = p_q[47] ? p_q[22] : p_q[21];
    s_bit    = p_q[47] ? (|p_q[21:0]) : (|p_q[20:0]);
    rnd_up   = g_bit & (r_bit | s_bit | frac_t[0]);
    frac_rnd = {1'b0, frac_t} + {23'd0, rnd_up};
    // carry-out leaves frac_rnd[22:0] at zero and bumps the exponent
    frac_n   = frac_rnd[22:0];
    exp_n    = $signed(e_raw + {9'd0, frac_rnd[23]});
  end
`else
  always_comb begin
    frac_n = frac_t;
    exp_n  = $signed(e_raw);
  end
`endif

  always_comb begin
    ovf_n = 1'b0;
    unf_n = 1'b0;
    temp_result = {sign, exp_n[7:0], frac_n};
    if (exp_n >= 10'sd255) begin
      ovf_n = 1'b1;
      temp_result = {sign, FP_EXP_MAX, {FRAC_W{1'b0}}};
    end else if (exp_n <= 10'sd0) begin
      unf_n = 1'b1;
      temp_result = {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    end
  end

  export_result_mul u_export (
    .a_i           (a_q),
    .b_i           (b_q),
    .temp_result_i (temp_result),
    .result_o      (final_result),
    .special_o     (special)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    sum      = {1'b0, p_q[47:24]} + {1'b0, 1'b1, a_q[22:0]};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_MUL;
          a_d     = bus.A;
          b_d     = bus.B;
          p_d     = {24'd0, 1'b1, bus.B[22:0]};
          cnt_d   = 5'd24;
        end
      end
      ST_MUL: begin
        if (p_q[0]) p_d = {sum, p_q[23:1]};
        else        p_d = {1'b0, p_q[47:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_NORM;
      end
      ST_NORM: begin
        result_d = final_result;
        ovf_d    = ovf_n & ~special;
        unf_d    = unf_n & ~special;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.enable    = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_if bus();

  mul_seq u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    string       name;
  } vec_t;

  vec_t vecs[12];

`ifdef MUL_ROUND_EN
  localparam logic [31:0] RND_EXP = 32'h3FC0_0002;
`else
  localparam logic [31:0] RND_EXP = 32'h3FC0_0001;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives start for one cycle; returns #1 after the accept edge with the
  // operand inputs scrambled to show they are not needed after acceptance.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = 32'hDEAD_BEEF;
    bus.B = 32'h1234_5678;
  endtask

  // lat counts posedges from the accept edge (edge 0 = 1) until enable is seen.
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!bus.enable && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;

    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;

    vecs[0]  = '{32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 1'b0, 1'b0, "3x2"};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, "1.5x1.5"};
    vecs[2]  = '{32'h3F80_0001, 32'h3FC0_0000, RND_EXP,       1'b0, 1'b0, "round"};
    vecs[3]  = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, "ovf"};
    vecs[4]  = '{32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 1'b0, 1'b0, "neg2x1"};
    vecs[5]  = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1, "unf"};
    vecs[6]  = '{32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, "denorm"};
    vecs[7]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0, "infx0"};
    vecs[8]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, "neginf"};
    vecs[9]  = '{32'hFF00_0000, 32'h4000_0000, 32'hFF80_0000, 1'b1, 1'b0, "negovf"};
    vecs[10] = '{32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 1'b1, "negunf"};
    vecs[11] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0, "nan"};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_unf", 32'(bus.underflow), 32'h0);
    chk("rst_enable", 32'(bus.enable), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_busy"}, 32'(bus.busy), 32'h1);
      wait_done(1, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd26);
      chk({vecs[i].name, "_res"}, bus.result, vecs[i].res);
      chk({vecs[i].name, "_ovf"}, 32'(bus.overflow), 32'(vecs[i].ovf));
      chk({vecs[i].name, "_unf"}, 32'(bus.underflow), 32'(vecs[i].unf));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_en1cyc"}, 32'(bus.enable), 32'h0);
      chk({vecs[i].name, "_idle"}, 32'(bus.busy), 32'h0);
      chk({vecs[i].name, "_hold"}, bus.result, vecs[i].res);
    end

    // start raised during DONE is dropped, then accepted in the IDLE cycle
    launch(32'h4040_0000, 32'h4000_0000);
    wait_done(1, lat);
    chk("b2b_first_lat", 32'(lat), 32'd26);
    bus.start = 1'b1;
    bus.A = 32'h3FC0_0000;
    bus.B = 32'h3FC0_0000;
    @(posedge clk);
    #1;
    chk("b2b_done_drop", 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_accept", 32'(bus.busy), 32'h1);
    wait_done(1, lat);
    chk("b2b_interval", 32'(lat + 1), 32'd27);
    chk("b2b_res", bus.result, 32'h4010_0000);
    @(posedge clk);
    #1;

    // second start at edge 5 is ignored
    launch(32'h4040_0000, 32'h4000_0000);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.A = 32'h7F80_0000;
    bus.B = 32'h0000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(6, lat);
    chk("ign_lat", 32'(lat), 32'd26);
    chk("ign_res", bus.result, 32'h40C0_0000);
    @(posedge clk);
    #1;
    chk("ign_idle", 32'(bus.busy), 32'h0);

    // reset at edge 12 of a new operation
    launch(32'hC000_0000, 32'h3F80_0000);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", bus.result, 32'h0);
    chk("abort_ovf", 32'(bus.overflow), 32'h0);
    chk("abort_unf", 32'(bus.underflow), 32'h0);
    chk("abort_enable", 32'(bus.enable), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(32'h3FC0_0000, 32'h3FC0_0000);
    wait_done(1, lat);
    chk("restart_lat", 32'(lat), 32'd26);
    chk("restart_res", bus.result, 32'h4010_0000);
    chk("restart_ovf", 32'(bus.overflow), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential IEEE-754 single-precision multiplier; the multiplicative counterpart of the restoring divider in the floating-point calculator datapath. A start pulse launches a radix-2 shift-add mantissa multiply over 24 cycles, followed by one cycle that normalises and packs the result. Unlike the divider, operands are captured on an explicit start handshake, so the block runs repeatedly without reset. Output flags and the `enable` done strobe use the divider's conventions, so the calculator top-level muxes both blocks identically.

## Interface
- No parameters; widths fixed for binary32.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-low reset
- start  in  1  operation request; sampled only in IDLE
- A  in  32  multiplicand (binary32)
- B  in  32  multiplier (binary32)
- result  out  32  product, held until the next accepted start
- overflow  out  1  exponent overflow; result forced to signed infinity
- underflow  out  1  exponent underflow; result forced to signed zero
- enable  out  1  one-cycle done strobe; result and flags valid while high and thereafter
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MUL, NORM, DONE.
  - IDLE→MUL on `start`. Latch sign = A[31]^B[31], exponents, mantissas {1,frac}. Set counter = 24 and accumulator P[47:0] = 0.
  - MUL: each cycle, if multiplier LSB = 1, add multiplicand into the upper half. Shift the {carry,P} pair right by 1 and decrement the counter. When the counter reaches 0, go to NORM.
  - NORM: normalise, compute exponent, apply special cases, register outputs, go to DONE.
  - DONE: `enable` = 1 for this cycle only, then go to IDLE.
- Exponent math is 10-bit signed: E = expA + expB − 127 + P[47].
- Mantissa: if P[47] = 1, frac = P[46:24]; otherwise frac = P[45:23].
- Overflow: E ≥ 255 → overflow = 1, result = {sign, 8'hFF, 0}.
- Underflow: E ≤ 0 → underflow = 1, result = {sign, 0, 0}.
- Special cases are decided on the latched operands and take priority over the flags. In all special cases overflow = underflow = 0.
  - Either operand NaN, or inf × zero → 32'h7FC00000.
  - Either operand inf → {sign, 8'hFF, 0}.
  - Either operand has exponent 0 (zero or denormal; denormals are flushed) → {sign, 0, 0}.
- `start` is ignored while busy. A and B may change freely after the accept edge.

## Timing
- Reset values: result = 0, overflow = 0, underflow = 0, enable = 0, busy = 0, state = IDLE.
- Reset asserted in any state aborts the operation immediately; outputs return to their reset values.
- Cycle accounting, with the accept edge as edge 0:
  - MUL occupies edges 1–24.
  - NORM registers the outputs at edge 25; `enable` and the new result are visible after edge 25.
  - State returns to IDLE at edge 26.
- Fixed latency: 26 clocks from accept to `enable`, including special cases, which also run the full MUL sequence.
- Back-to-back: `start` held high in the IDLE cycle after DONE is accepted, giving a 27-cycle issue interval.
- `busy` rises after edge 0 and falls after edge 26.
- `start` in DONE is dropped, not queued.

## Configuration
- `MUL_ROUND_EN` defined: round-to-nearest-even using guard, round and sticky bits from P.
  - Mantissa carry-out renormalises: frac = 0, E + 1.
  - The overflow check uses the post-rounding E.
- `MUL_ROUND_EN` undefined: truncation, matching the divider. The rounding logic is absent.

## Structure
- Shared package `fp_pkg`:
  - FSM state typedef
  - constants FP_BIAS = 127, FP_QNAN = 32'h7FC00000, FP_EXP_MAX = 8'hFF
  - field widths (EXP_W = 8, FRAC_W = 23)
- Sub-module `export_result_mul`: combinational special-case override, taking (A, B, temp_result) to result. Mirrors the divider's export stage.

## Test plan
- 40400000 × 40000000 (3×2) → result 40C00000; enable exactly 26 cycles after accept; flags 0.
- 3FC00000 × 3FC00000 (1.5×1.5) → 40100000, exercising P[47] = 1 normalisation. Then 3F800001 × 3FC00000:
  - → 3FC00001 without `MUL_ROUND_EN`
  - → 3FC00002 with `MUL_ROUND_EN` (tie to even)
- 7F000000 × 40000000 → overflow = 1, result 7F800000. Then C0000000 × 3F800000 → C0000000, flags 0.
- 00800000 × 00800000 → underflow = 1, result 00000000. Then 00400000 (denormal) × 40000000 → 00000000, underflow = 0.
- 7F800000 × 00000000 → 7FC00000. FF800000 × 40000000 → FF800000.
- Pulse start at edge 0. Pulse start again at edge 5 with different operands → ignored, first result returned. Then assert RST at edge 12 of a new operation → all outputs 0 and busy = 0 immediately. Start again after release → correct result.
